ctx_queue: RTL and testbench

Context save/restore engine for the thread register file: snapshots a 256-bit register context (regs 0-7) plus a 32-bit PC tag into an internal FIFO on a save request, and later replays the oldest context back into the register file on a restore request. It is the initiator for the register file's bulk-read (`give_me`/`the_regs`) and bulk-write (`writing_regs`/`change_me`) ports. It sits between the work-queue scheduler and the register file. While `busy` is high, the scheduler holds off all other register reads and writes.

---
 rtl/ctx_queue.sv | 160 ++++++++++++++++
 tb/tb_ctx_queue.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctx_queue.sv
`default_nettype none
// ============================================================================
// Module   : ctx_queue
// Brief    : Context save/restore engine. Snapshots the 256-bit register
//            context plus a 32-bit PC tag into a FIFO on save, and replays
//            the oldest context into the register file on restore.
// Revision : 1.0 - initial release
// ============================================================================
module ctx_queue #(
  parameter int DEPTH    = 4,
  parameter int SNAP_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     save_req,
  input  logic [31:0]              save_pc,
  output logic                     save_ack,
  input  logic                     restore_req,
  output logic                     restore_ack,
  output logic [31:0]              restore_pc,
  output logic                     err,
  output logic                     give_me,
  input  logic [255:0]             the_regs,
  output logic                     writing_regs,
  output logic [255:0]             change_me,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = (SNAP_LAT > 1) ? $clog2(SNAP_LAT) : 1;
  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] SNAP_LAST = CNT_W'(SNAP_LAT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SNAP   = 3'd1,
    PUSH   = 3'd2,
    LOAD   = 3'd3,
    SETTLE = 3'd4,
    REJ    = 3'd5
  } state_t;

  state_t             r_state;
  logic [255:0]       r_mem    [DEPTH];
  logic [31:0]        r_pc_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_snap_cnt;
  logic [31:0]        r_pc;

  logic w_full;
  logic w_empty;
  logic w_capture;

  assign w_full    = (count == DEPTH_CNT);
  assign w_empty   = (count == '0);
  // The snapshot is valid once give_me has been held for SNAP_LAT cycles.
  assign w_capture = (r_state == SNAP) && (r_snap_cnt == SNAP_LAST);

  // Context storage: written only on the final snapshot cycle, never reset.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_mem[r_wr_ptr]    <= the_regs;
      r_pc_mem[r_wr_ptr] <= r_pc;
    end
  end

  // Control FSM with registered outputs; each output is set on entry to its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_snap_cnt   <= '0;
      r_pc         <= '0;
      count        <= '0;
      save_ack     <= 1'b0;
      restore_ack  <= 1'b0;
      restore_pc   <= '0;
      err          <= 1'b0;
      give_me      <= 1'b0;
      writing_regs <= 1'b0;
      change_me    <= '0;
      busy         <= 1'b0;
    end else begin
      save_ack     <= 1'b0;
      restore_ack  <= 1'b0;
      restore_pc   <= '0;
      err          <= 1'b0;
      give_me      <= 1'b0;
      writing_regs <= 1'b0;
      change_me    <= '0;
      case (r_state)
        IDLE: begin
          if (save_req) begin
            busy <= 1'b1;
            if (w_full) begin
              r_state  <= REJ;
              save_ack <= 1'b1;
              err      <= 1'b1;
            end else begin
              r_state    <= SNAP;
              r_pc       <= save_pc;
              r_snap_cnt <= '0;
              give_me    <= 1'b1;
            end
          end else if (restore_req) begin
            busy <= 1'b1;
            if (w_empty) begin
              r_state     <= REJ;
              restore_ack <= 1'b1;
              err         <= 1'b1;
            end else begin
              r_state      <= LOAD;
              writing_regs <= 1'b1;
              change_me    <= r_mem[r_rd_ptr];
            end
          end
        end
        SNAP: begin
          r_snap_cnt <= r_snap_cnt + CNT_W'(1);
          if (w_capture) begin
            r_state  <= PUSH;
            save_ack <= 1'b1;
          end else begin
            give_me <= 1'b1;
          end
        end
        PUSH: begin
          r_wr_ptr <= r_wr_ptr + PTR_W'(1);
          count    <= count + (PTR_W + 1)'(1);
          r_state  <= IDLE;
          busy     <= 1'b0;
        end
        LOAD: begin
          r_state     <= SETTLE;
          restore_ack <= 1'b1;
          restore_pc  <= r_pc_mem[r_rd_ptr];
        end
        SETTLE: begin
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
          count    <= count - (PTR_W + 1)'(1);
          r_state  <= IDLE;
          busy     <= 1'b0;
        end
        REJ: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ctx_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctx_queue
// Brief    : Self-checking bench for ctx_queue: vector table of save/restore
//            operations, FIFO scoreboard of saved contexts, and hand-written
//            sequences for reset, priority, wrap and held requests.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctx_queue;

  localparam int DEPTH    = 4;
  localparam int SNAP_LAT = 2;
  localparam int CW       = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst_n;
  logic          save_req;
  logic [31:0]   save_pc;
  logic          save_ack;
  logic          restore_req;
  logic          restore_ack;
  logic [31:0]   restore_pc;
  logic          err;
  logic          give_me;
  logic [255:0]  the_regs;
  logic          writing_regs;
  logic [255:0]  change_me;
  logic          busy;
  logic [CW-1:0] count;

  logic [255:0]  snap_val;
  int            gm_cnt;

  int n_tests;
  int n_fail;

  typedef struct {
    logic [31:0]  pc;
    logic [255:0] regs;
  } ctx_t;

  ctx_t sb[$];

  typedef struct {
    bit           is_save;
    logic [31:0]  pc;
    logic [255:0] regs;
    bit           exp_err;
    int           exp_count;
  } vec_t;

  vec_t vecs[12];

  ctx_queue #(.DEPTH(DEPTH), .SNAP_LAT(SNAP_LAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .save_req     (save_req),
    .save_pc      (save_pc),
    .save_ack     (save_ack),
    .restore_req  (restore_req),
    .restore_ack  (restore_ack),
    .restore_pc   (restore_pc),
    .err          (err),
    .give_me      (give_me),
    .the_regs     (the_regs),
    .writing_regs (writing_regs),
    .change_me    (change_me),
    .busy         (busy),
    .count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file model: snapshot data is only valid after SNAP_LAT cycles of give_me.
  always @(posedge clk) gm_cnt <= give_me ? gm_cnt + 1 : 0;
  assign the_regs = (give_me && gm_cnt == SNAP_LAT - 1) ? snap_val : ~snap_val;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [255:0] mk_regs(input logic [31:0] pc);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = {pc[15:0], 16'(i + 1)} ^ 32'hA5A5_0000;
    return r;
  endfunction

  // Save: expectation pushed when the request is driven.
  task automatic do_save(input logic [31:0] pc, input logic [255:0] regs, output bit got_err);
    int  gm;
    int  ackc;
    bit  seen_wr;
    bit  e;
    bit  accept;
    accept   = (sb.size() < DEPTH);
    save_pc  = pc;
    snap_val = regs;
    save_req = 1'b1;
    if (accept) sb.push_back('{pc, regs});
    gm = 0; ackc = 0; seen_wr = 0; e = 0;
    for (int k = 1; k <= 50; k++) begin
      @(posedge clk); #1;
      if (give_me) gm++;
      if (writing_regs) seen_wr = 1;
      if (save_ack) begin
        ackc = k;
        e    = err;
        break;
      end
    end
    save_req = 1'b0;
    chk("save_ack_seen", ackc != 0, 1);
    chk("save_ack_cycle", ackc, accept ? SNAP_LAT + 1 : 1);
    chk("save_give_me_cycles", gm, accept ? SNAP_LAT : 0);
    chk("save_err", e, !accept);
    chk("save_no_write", seen_wr, 0);
    @(posedge clk); #1;
    chk("save_idle_busy", busy, 0);
    chk("save_count", count, sb.size());
    got_err = e;
  endtask

  // Restore: expectation popped when the DUT acknowledges.
  task automatic do_restore(output bit got_err);
    int           ackc;
    int           wrc;
    int           gm;
    bit           e;
    bit           accept;
    logic [255:0] cm;
    logic [31:0]  rpc;
    ctx_t         exp_ctx;
    accept      = (sb.size() > 0);
    restore_req = 1'b1;
    ackc = 0; wrc = 0; gm = 0; e = 0; cm = '0; rpc = '0;
    for (int k = 1; k <= 50; k++) begin
      @(posedge clk); #1;
      if (give_me) gm++;
      if (writing_regs) begin
        wrc = k;
        cm  = change_me;
      end
      if (restore_ack) begin
        ackc = k;
        rpc  = restore_pc;
        e    = err;
        break;
      end
    end
    restore_req = 1'b0;
    chk("restore_ack_seen", ackc != 0, 1);
    chk("restore_ack_cycle", ackc, accept ? 2 : 1);
    chk("restore_write_cycle", wrc, accept ? 1 : 0);
    chk("restore_err", e, !accept);
    chk("restore_no_snap", gm, 0);
    if (accept) begin
      exp_ctx = sb.pop_front();
      chk("restore_change_me", cm, exp_ctx.regs);
      chk("restore_pc", rpc, exp_ctx.pc);
    end else begin
      chk("restore_pc_on_err", rpc, 0);
    end
    @(posedge clk); #1;
    chk("restore_idle_busy", busy, 0);
    chk("restore_idle_pc_zero", restore_pc, 0);
    chk("restore_idle_change_me_zero", change_me, 0);
    chk("restore_count", count, sb.size());
    got_err = e;
  endtask

  initial begin : main
    bit e;
    int ok_cnt;
    int rej_cnt;
    int idle_cnt;
    int dbl_idle;
    bit prev_idle;
    n_tests = 0; n_fail = 0;
    save_req = 0; restore_req = 0; save_pc = '0; snap_val = '0;

    vecs[0]  = '{1'b1, 32'h40, 256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888, 1'b0, 1};
    vecs[1]  = '{1'b0, 32'h0,  '0,              1'b0, 0};
    vecs[2]  = '{1'b0, 32'h0,  '0,              1'b1, 0};
    vecs[3]  = '{1'b1, 32'h10, mk_regs(32'h10), 1'b0, 1};
    vecs[4]  = '{1'b1, 32'h11, mk_regs(32'h11), 1'b0, 2};
    vecs[5]  = '{1'b1, 32'h12, mk_regs(32'h12), 1'b0, 3};
    vecs[6]  = '{1'b1, 32'h13, mk_regs(32'h13), 1'b0, 4};
    vecs[7]  = '{1'b1, 32'h99, mk_regs(32'h99), 1'b1, 4};
    vecs[8]  = '{1'b0, 32'h0,  '0,              1'b0, 3};
    vecs[9]  = '{1'b0, 32'h0,  '0,              1'b0, 2};
    vecs[10] = '{1'b0, 32'h0,  '0,              1'b0, 1};
    vecs[11] = '{1'b0, 32'h0,  '0,              1'b0, 0};

    // Reset held with random inputs: every output must stay at zero.
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      save_req    = 1'($urandom);
      restore_req = 1'($urandom);
      save_pc     = $urandom;
      snap_val    = {8{$urandom}};
      #2;
      chk("reset_ctrl_outputs", {save_ack, restore_ack, err, give_me, writing_regs, busy}, 0);
      chk("reset_count", count, 0);
      chk("reset_data_outputs", {restore_pc, change_me[31:0]}, 0);
      chk("reset_change_me", change_me, 0);
    end
    save_req = 0; restore_req = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Vector table: single save/restore, empty, full.
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].is_save) do_save(vecs[i].pc, vecs[i].regs, e);
      else                 do_restore(e);
      chk("vec_err", e, vecs[i].exp_err);
      chk("vec_count", count, vecs[i].exp_count);
    end

    // Priority: with one stored context, both requests together run the save first.
    do_save(32'h20, mk_regs(32'h20), e);
    restore_req = 1'b1;
    do_save(32'h21, mk_regs(32'h21), e);
    do_restore(e);
    do_restore(e);

    // Pointer wrap with save/restore pairs.
    for (int i = 0; i < 6; i++) begin
      do_save(32'h60 + 32'(i), mk_regs(32'h60 + 32'(i)), e);
      do_restore(e);
    end

    // Held save request for 20 cycles: four accepts, then refusals.
    ok_cnt = 0; rej_cnt = 0; idle_cnt = 0; dbl_idle = 0; prev_idle = 0;
    save_pc  = 32'h50;
    snap_val = mk_regs(32'h50);
    sb.push_back('{32'h50, mk_regs(32'h50)});
    save_req = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (save_ack) begin
        if (err) rej_cnt++;
        else begin
          ok_cnt++;
          if (sb.size() < DEPTH) begin
            save_pc  = 32'h50 + 32'(ok_cnt);
            snap_val = mk_regs(save_pc);
            sb.push_back('{save_pc, snap_val});
          end
        end
      end
      if (!busy) begin
        idle_cnt++;
        if (prev_idle) dbl_idle++;
      end
      prev_idle = !busy;
    end
    save_req = 1'b0;
    chk("held_accepted", ok_cnt, 4);
    chk("held_refused", rej_cnt, 2);
    chk("held_idle_cycles", idle_cnt, 6);
    chk("held_double_idle", dbl_idle, 0);
    @(posedge clk); #1;
    chk("held_count", count, 4);
    for (int i = 0; i < 4; i++) do_restore(e);

    // Reset during SNAP abandons the save and clears the count.
    do_save(32'h70, mk_regs(32'h70), e);
    save_pc  = 32'h71;
    snap_val = mk_regs(32'h71);
    save_req = 1'b1;
    @(posedge clk); #1;
    chk("snap_give_me_before_rst", give_me, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_give_me_async", give_me, 0);
    chk("rst_count_async", count, 0);
    chk("rst_busy_async", busy, 0);
    save_req = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_restore(e);
    chk("post_rst_empty_err", e, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
